// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;

  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue (reserve), cleared at writeback (release).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             rel_en,
  input  logic [AW-1:0]    rel_addr,
  output logic [NREGS-1:0] busy
);

  logic rsv_ok;

  assign rsv_ok = en && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Release first, reserve second, so a same-cycle reserve to the same register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (rel_en) busy[rel_addr] <= 1'b0;
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/param_register_file.sv
// Parametrised multi-port register file with write bypass, post-reset clear sweep and busy scoreboard.
module param_register_file
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output rf_state_t           state
);

  logic [XLEN-1:0]  mem [NREGS];
  rf_state_t        state_q;
  rf_state_t        state_d;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;
  logic [NREGS-1:0] busy;

  assign ready = (state_q == READY);
  assign state = state_q;
  assign wr_ok = ready && we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == CLEAR) && (clr_idx == AW'(NREGS - 1))) state_d = READY;
  end

  // Storage has no reset; the sweep zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (ready),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rel_en   (wr_ok),
    .rel_addr (waddr),
    .busy     (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] word;
    logic            bsy;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
      word = mem[ra];
      bsy  = busy[ra];
      if (!ready) begin
        word = '0;
        bsy  = 1'b0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        word = '0;
        bsy  = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (waddr == ra)) begin
        word = wdata;
        bsy  = 1'b0;
      end
    end

    assign rdata[i*XLEN +: XLEN] = word;
    assign rbusy[i]              = bsy;
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: dut_a (NRD=4, bypass) and dut_b (NRD=2, no bypass) share write/reserve inputs.
module tb_param_register_file;
  import regfile_pkg::*;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [4:0]  ra0 = '0;
  logic [4:0]  ra1 = '0;

  logic         ready_a, ready_b;
  logic [127:0] rdata_a;
  logic [63:0]  rdata_b;
  logic [3:0]   rbusy_a;
  logic [1:0]   rbusy_b;
  rf_state_t    state_a, state_b;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  param_register_file #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr({ra1, ra1, ra1, ra0}), .rdata(rdata_a), .rbusy(rbusy_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .state(state_a)
  );

  param_register_file #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr({ra1, ra0}), .rdata(rdata_b), .rbusy(rbusy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .state(state_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_a0;
    logic        exp_busy_a0;
    logic [31:0] exp_b0;
    logic        exp_busy_b0;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rv, input logic [4:0] rva,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] ea0, input logic eba0,
                              input logic [31:0] eb0, input logic ebb0,
                              input logic [31:0] ea1);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.rsv_en = rv; v.rsv_addr = rva;
    v.ra0 = r0; v.ra1 = r1; v.exp_a0 = ea0; v.exp_busy_a0 = eba0;
    v.exp_b0 = eb0; v.exp_busy_b0 = ebb0; v.exp_a1 = ea1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;

    vecs[0]  = mk(1, 5, 32'hdeadbeef, 0, 0, 5, 5, 32'hdeadbeef, 0, 32'h0,        0, 32'hdeadbeef);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 5, 5, 32'hdeadbeef, 0, 32'hdeadbeef, 0, 32'hdeadbeef);
    vecs[2]  = mk(1, 0, 32'hffffffff, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 7, 7, 5, 32'h0,        0, 32'h0,        0, 32'hdeadbeef);
    vecs[5]  = mk(1, 7, 32'h12345678, 0, 0, 7, 7, 32'h12345678, 0, 32'h0,        1, 32'h12345678);
    vecs[6]  = mk(0, 0, 32'h0,        0, 0, 7, 7, 32'h12345678, 0, 32'h12345678, 0, 32'h12345678);
    vecs[7]  = mk(1, 7, 32'h00000055, 1, 7, 7, 7, 32'h00000055, 0, 32'h12345678, 0, 32'h00000055);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 7, 7, 32'h00000055, 1, 32'h00000055, 1, 32'h00000055);
    vecs[9]  = mk(1, 9, 32'h000000aa, 0, 0, 3, 9, 32'h0,        0, 32'h0,        0, 32'h000000aa);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 9, 9, 32'h000000aa, 0, 32'h000000aa, 0, 32'h000000aa);
    vecs[11] = mk(1, 3, 32'h00000001, 0, 0, 3, 7, 32'h00000001, 0, 32'h0,        0, 32'h00000055);
    vecs[12] = mk(0, 0, 32'h0,        0, 0, 3, 3, 32'h00000001, 0, 32'h00000001, 0, 32'h00000001);

    // Reset, then a sweep with writes/reserves aimed at reg 5 that must be ignored.
    rst = 1'b1;
    tick();
    tick();
    check("reset_ready_a", 32'(ready_a), 32'h0);
    check("reset_state_a", 32'(state_a), 32'(CLEAR));
    rst = 1'b0;
    we = 1'b1; waddr = 5; wdata = 32'hcafef00d; rsv_en = 1'b1; rsv_addr = 5; ra0 = 5; ra1 = 5;
    for (int c = 1; c <= 32; c++) begin
      check("sweep_rdata_a0", rdata_a[31:0], 32'h0);
      check("sweep_rbusy_a0", 32'(rbusy_a[0]), 32'h0);
      tick();
      check("sweep_ready_a", 32'(ready_a), (c == 32) ? 32'h1 : 32'h0);
      check("sweep_ready_b", 32'(ready_b), (c == 32) ? 32'h1 : 32'h0);
    end
    we = 1'b0; rsv_en = 1'b0;
    for (int r = 1; r < 32; r++) begin
      ra0 = 5'(r);
      #1;
      check("post_sweep_rdata_a0", rdata_a[31:0], 32'h0);
      check("post_sweep_rbusy_a0", 32'(rbusy_a[0]), 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #1;
      check($sformatf("v%0d_rdata_a0", i), rdata_a[31:0], vecs[i].exp_a0);
      check($sformatf("v%0d_rbusy_a0", i), 32'(rbusy_a[0]), 32'(vecs[i].exp_busy_a0));
      check($sformatf("v%0d_rdata_b0", i), rdata_b[31:0], vecs[i].exp_b0);
      check($sformatf("v%0d_rbusy_b0", i), 32'(rbusy_b[0]), 32'(vecs[i].exp_busy_b0));
      for (int p = 1; p < 4; p++)
        check($sformatf("v%0d_rdata_a%0d", i, p), rdata_a[p*32 +: 32], vecs[i].exp_a1);
      tick();
    end

    // Mid-operation reset: busy bits and contents must be cleared by the new sweep.
    we = 1'b0; rsv_en = 1'b1; rsv_addr = 3; ra0 = 3; ra1 = 3;
    tick();
    rsv_en = 1'b0;
    #1;
    check("rsv3_rbusy_a0", 32'(rbusy_a[0]), 32'h1);
    rst = 1'b1;
    tick();
    check("midrst_ready_a", 32'(ready_a), 32'h0);
    check("midrst_rdata_a0", rdata_a[31:0], 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (!ready_a && cnt < 40) begin
      tick();
      cnt++;
    end
    check("midrst_sweep_cycles", 32'(cnt), 32'd32);
    check("midrst_ready_b", 32'(ready_b), 32'h1);
    #1;
    check("midrst_reg3_rdata_a0", rdata_a[31:0], 32'h0);
    check("midrst_reg3_rdata_b0", rdata_b[31:0], 32'h0);
    check("midrst_reg3_rbusy_a0", 32'(rbusy_a[0]), 32'h0);
    ra0 = 7;
    #1;
    check("midrst_reg7_rbusy_a0", 32'(rbusy_a[0]), 32'h0);
    check("midrst_reg7_rdata_b0", rdata_b[31:0], 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
